// File: rtl/clk_edge_monitor.sv
// clk_edge_monitor
//
// Receive-side companion to the 100 MHz -> 25 MHz SD clock divider. Samples
// the divided clock in the clk_100mhz domain and turns its edges into
// single-cycle strobes. It also measures the rise-to-rise period, declares
// lock after a run of in-tolerance periods, and flags loss of lock.
//
// Optional feature macro: CLK_MON_STATS_EN
//   When it is defined, bad_cnt counts bad periods and timeout entries,
//   saturating at 16'hFFFF. When it is undefined, bad_cnt is tied to zero.
//
// Ports:
//   clk_100mhz   in   system clock
//   rst_n        in   asynchronous active-low reset
//   clk_in       in   monitored divided clock (asynchronous)
//   clear_err    in   single-cycle clear of err_sticky (a set wins)
//   rise_stb     out  one-cycle strobe per detected rising edge
//   fall_stb     out  one-cycle strobe per detected falling edge
//   period       out  last measured rise-to-rise period, in clk_100mhz cycles
//   period_valid out  period holds a real measurement
//   locked       out  divided clock is stable within tolerance
//   err_sticky   out  lock was lost since the last clear
//   bad_cnt      out  saturating count of bad periods and timeouts
module clk_edge_monitor #(
  parameter int EXPECTED_PERIOD = 4,
  parameter int TOLERANCE       = 0,
  parameter int LOCK_COUNT      = 8,
  parameter int TIMEOUT         = 64,
  parameter int PERIOD_W        = 8
) (
  input  logic                clk_100mhz,
  input  logic                rst_n,
  input  logic                clk_in,
  input  logic                clear_err,
  output logic                rise_stb,
  output logic                fall_stb,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic                err_sticky,
  output logic [15:0]         bad_cnt
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [PERIOD_W-1:0] TIMEOUT_V  = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W-1:0] TIMEOUT_M1 = PERIOD_W'(TIMEOUT - 1);
  localparam logic [GOOD_W-1:0]   LOCK_V     = GOOD_W'(LOCK_COUNT);

  // Tolerance window bounds. The lower bound is clamped at zero so a large
  // tolerance never wraps the unsigned comparison.
  localparam logic [31:0] GOOD_LO = (EXPECTED_PERIOD > TOLERANCE) ?
                                    32'(EXPECTED_PERIOD - TOLERANCE) : 32'd0;
  localparam logic [31:0] GOOD_HI = 32'(EXPECTED_PERIOD + TOLERANCE);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  logic                s0;
  logic                s1;
  logic                s2;
  logic [PERIOD_W-1:0] cnt;
  logic                have_ref;
  state_t              state;
  logic [GOOD_W-1:0]   good_cnt;

  logic                rise;
  logic                fall;
  logic [PERIOD_W-1:0] meas;
  logic [31:0]         meas_ext;
  logic                meas_valid;
  logic                period_good;
  logic                timeout_hit;
  logic                lock_lost;

  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;

  // cnt is zeroed on the strobe edge of a rise, so the rise-to-rise distance
  // is one more than the count held in the cycle before the next strobe.
  assign meas     = cnt + PERIOD_W'(1);
  assign meas_ext = 32'(meas);

  // Only a rise that follows another rise (with no timeout in between)
  // carries a real measurement. have_ref can only be set while cnt is below
  // TIMEOUT, so meas never wraps here.
  assign meas_valid  = rise & have_ref;
  assign period_good = (meas_ext >= GOOD_LO) && (meas_ext <= GOOD_HI);

  // Fires on the single cycle whose edge brings cnt up to TIMEOUT; once cnt
  // sits at TIMEOUT it stops counting, so this never re-fires until a rise.
  assign timeout_hit = ~rise & (cnt == TIMEOUT_M1);

  assign lock_lost = (state == LOCKED) &
                     (timeout_hit | (meas_valid & ~period_good));

  // Synchronizer, edge strobes and period measurement.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      s0           <= 1'b0;
      s1           <= 1'b0;
      s2           <= 1'b0;
      rise_stb     <= 1'b0;
      fall_stb     <= 1'b0;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      have_ref     <= 1'b0;
    end else begin
      s0       <= clk_in;
      s1       <= s0;
      s2       <= s1;
      rise_stb <= rise;
      fall_stb <= fall;

      if (rise) begin
        cnt <= '0;
      end else if (cnt != TIMEOUT_V) begin
        cnt <= cnt + PERIOD_W'(1);
      end

      if (meas_valid) begin
        period <= meas;
      end

      if (rise) begin
        have_ref <= 1'b1;
      end else if (timeout_hit) begin
        have_ref <= 1'b0;
      end

      if (meas_valid) begin
        period_valid <= 1'b1;
      end else if (timeout_hit) begin
        period_valid <= 1'b0;
      end
    end
  end

  // Lock FSM. In ACQUIRE the lock is granted by a good rise that arrives
  // after LOCK_COUNT good periods are already counted, so the final rise
  // confirms the run rather than merely completing it.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= UNLOCKED;
      good_cnt   <= '0;
      locked     <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        UNLOCKED: begin
          if (rise) begin
            state    <= ACQUIRE;
            good_cnt <= '0;
          end
        end
        ACQUIRE: begin
          if (timeout_hit) begin
            state <= UNLOCKED;
          end else if (meas_valid) begin
            if (!period_good) begin
              good_cnt <= '0;
            end else if (good_cnt == LOCK_V) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              good_cnt <= good_cnt + GOOD_W'(1);
            end
          end
        end
        LOCKED: begin
          if (lock_lost) begin
            state  <= UNLOCKED;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= UNLOCKED;
          locked <= 1'b0;
        end
      endcase

      // A loss in the same cycle as a clear keeps the flag set.
      if (lock_lost) begin
        err_sticky <= 1'b1;
      end else if (clear_err) begin
        err_sticky <= 1'b0;
      end
    end
  end

`ifdef CLK_MON_STATS_EN
  logic bad_event;

  assign bad_event = timeout_hit | (meas_valid & ~period_good);

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      bad_cnt <= '0;
    end else if (bad_event && (bad_cnt != 16'hFFFF)) begin
      bad_cnt <= bad_cnt + 16'd1;
    end
  end
`else
  assign bad_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_clk_edge_monitor.sv
// tb_clk_edge_monitor
//
// Self-checking bench for clk_edge_monitor. Stimulus is a per-cycle plan of
// clk_in levels (and clear_err pulses). A reference model works from event
// times: it finds rises/falls from the level history delayed by the
// synchronizer latency, measures periods as the distance between rise
// strobes, and declares a timeout TIMEOUT cycles after the last rise.
// Honours CLK_MON_STATS_EN for the expected bad_cnt.
module tb_clk_edge_monitor;

  localparam int EXP   = 4;
  localparam int TOL   = 0;
  localparam int LOCKN = 8;
  localparam int TMO   = 64;
  localparam int PW    = 8;
  localparam int VW    = PW + 21;

  logic          clk_100mhz = 1'b0;
  logic          rst_n      = 1'b0;
  logic          clk_in     = 1'b0;
  logic          clear_err  = 1'b0;
  logic          rise_stb;
  logic          fall_stb;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          err_sticky;
  logic [15:0]   bad_cnt;

  clk_edge_monitor #(
    .EXPECTED_PERIOD (EXP),
    .TOLERANCE       (TOL),
    .LOCK_COUNT      (LOCKN),
    .TIMEOUT         (TMO),
    .PERIOD_W        (PW)
  ) dut (
    .clk_100mhz   (clk_100mhz),
    .rst_n        (rst_n),
    .clk_in       (clk_in),
    .clear_err    (clear_err),
    .rise_stb     (rise_stb),
    .fall_stb     (fall_stb),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .err_sticky   (err_sticky),
    .bad_cnt      (bad_cnt)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus plan
  bit plan_lvl[$];
  bit plan_clr[$];

  // Reference model state
  int          k;
  bit          lvl_hist[$];
  int          m_last_ref;
  bit          m_have_ref;
  int          m_period;
  bit          m_valid;
  bit          m_locked;
  bit          m_acq;
  int          m_good;
  bit          m_err;
  int          m_bad;
  bit          m_rise;
  bit          m_fall;
  logic [VW-1:0] exp_vec;

  wire logic [VW-1:0] dut_vec = {rise_stb, fall_stb, period, period_valid,
                                 locked, err_sticky, bad_cnt};

  function automatic logic [15:0] exp_bad();
`ifdef CLK_MON_STATS_EN
    return 16'(m_bad);
`else
    return 16'd0;
`endif
  endfunction

  function automatic void build_exp();
    exp_vec = {m_rise, m_fall, PW'(m_period), m_valid, m_locked, m_err, exp_bad()};
  endfunction

  // clk_in level sampled at edge j (edges numbered from 1 after reset).
  function automatic bit level(input int j);
    if (j < 1 || j > lvl_hist.size()) return 1'b0;
    return lvl_hist[j-1];
  endfunction

  function automatic void model_reset();
    k = 0;
    lvl_hist.delete();
    m_last_ref = 0;
    m_have_ref = 0;
    m_period   = 0;
    m_valid    = 0;
    m_locked   = 0;
    m_acq      = 0;
    m_good     = 0;
    m_err      = 0;
    m_bad      = 0;
    m_rise     = 0;
    m_fall     = 0;
    build_exp();
  endfunction

  function automatic void model_edge(input bit clr);
    bit r;
    bit f;
    bit good;
    bit set_err;
    int meas;
    k++;
    // A level applied at edge j shows up as a strobe after edge j+2.
    r = level(k-2) & ~level(k-3);
    f = ~level(k-2) & level(k-3);
    set_err = 0;
    m_rise = r;
    m_fall = f;
    if (r) begin
      if (m_have_ref) begin
        meas     = k - m_last_ref;
        m_period = meas;
        m_valid  = 1;
        good     = (meas >= EXP - TOL) && (meas <= EXP + TOL);
        if (!good) m_bad++;
        if (m_locked) begin
          if (!good) begin
            m_locked = 0;
            set_err  = 1;
          end
        end else if (m_acq) begin
          if (!good) m_good = 0;
          else if (m_good == LOCKN) begin
            m_locked = 1;
            m_acq    = 0;
          end else m_good++;
        end else begin
          m_acq  = 1;
          m_good = 0;
        end
      end else begin
        m_acq  = 1;
        m_good = 0;
      end
      m_have_ref = 1;
      m_last_ref = k;
    end else if (k - m_last_ref == TMO) begin
      m_valid    = 0;
      m_have_ref = 0;
      m_bad++;
      if (m_locked) set_err = 1;
      m_locked = 0;
      m_acq    = 0;
    end
    if (set_err) m_err = 1;
    else if (clr) m_err = 0;
    if (m_bad > 65535) m_bad = 65535;
    build_exp();
  endfunction

  // Entered and left at a falling clock edge.
  task automatic step(input bit lv, input bit cl);
    clk_in    = lv;
    clear_err = cl;
    lvl_hist.push_back(lv);
    @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    model_edge(cl);
  endtask

  task automatic plan_period(input int hi, input int lo, input int clr_at);
    for (int i = 0; i < hi + lo; i++) begin
      plan_lvl.push_back(i < hi);
      plan_clr.push_back(i == clr_at);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_100mhz);
    rst_n     = 1'b0;
    clk_in    = 1'b0;
    clear_err = 1'b0;
    repeat (2) @(negedge clk_100mhz);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dut_vec !== {VW{1'b0}}) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=0", dut_vec);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d got=%h want=%h", k, dut_vec, exp_vec);
      end
    end
    $display("test_reset done k=%0d", k);
  endtask

  task automatic test_lock_acquire();
    int rises = 0;
    int lock_at = 0;
    bit lv;
    bit cl;
    for (int i = 0; i < 12; i++) plan_period(2, 2, -1);
    while (plan_lvl.size() > 0) begin
      lv = plan_lvl.pop_front();
      cl = plan_clr.pop_front();
      step(lv, cl);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL lock_model k=%0d got=%h want=%h", k, dut_vec, exp_vec);
      end
      if (rise_stb === 1'b1) begin
        rises++;
        n_checks++;
        if (period_valid !== (rises >= 2)) begin
          n_fail++;
          $display("FAIL lock_valid rise=%0d got=%b want=%b", rises, period_valid, rises >= 2);
        end
      end
      if (period_valid === 1'b1) begin
        n_checks++;
        if (period !== PW'(4)) begin
          n_fail++;
          $display("FAIL lock_period k=%0d got=%0d want=4", k, period);
        end
      end
      if (locked === 1'b1 && lock_at == 0) lock_at = rises;
    end
    n_checks++;
    if (lock_at != 10) begin
      n_fail++;
      $display("FAIL lock_at_rise got=%0d want=10", lock_at);
    end
    $display("test_lock_acquire done rises=%0d lock_at=%0d", rises, lock_at);
  endtask

  task automatic test_bad_period();
    bit bad_seen = 0;
    int rises_after = 0;
    int relock_at = 0;
    bit lv;
    bit cl;
    plan_period(3, 3, -1);
    for (int i = 0; i < 12; i++) plan_period(2, 2, -1);
    while (plan_lvl.size() > 0) begin
      lv = plan_lvl.pop_front();
      cl = plan_clr.pop_front();
      step(lv, cl);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL bad_model k=%0d got=%h want=%h", k, dut_vec, exp_vec);
      end
      if (rise_stb === 1'b1 && period === PW'(6)) begin
        bad_seen = 1;
        rises_after = 0;
        n_checks++;
        if (locked !== 1'b0 || err_sticky !== 1'b1) begin
          n_fail++;
          $display("FAIL bad_loss locked=%b err=%b want locked=0 err=1", locked, err_sticky);
        end
      end else if (rise_stb === 1'b1 && bad_seen) begin
        rises_after++;
      end
      if (bad_seen && locked === 1'b1 && relock_at == 0) relock_at = rises_after;
    end
    n_checks++;
    if (relock_at != 10) begin
      n_fail++;
      $display("FAIL bad_relock got=%0d want=10", relock_at);
    end
    $display("test_bad_period done relock_at=%0d", relock_at);
  endtask

  task automatic test_stopped_clock();
    int last_rise_k = 0;
    int drop_k = 0;
    int strobes_after = 0;
    bit prev_locked;
    bit lv;
    bit cl;
    prev_locked = locked;
    plan_period(2, 2, 0);
    plan_period(2, 2, -1);
    plan_period(0, 80, -1);
    while (plan_lvl.size() > 0) begin
      lv = plan_lvl.pop_front();
      cl = plan_clr.pop_front();
      step(lv, cl);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL stop_model k=%0d got=%h want=%h", k, dut_vec, exp_vec);
      end
      if (drop_k != 0 && (rise_stb === 1'b1 || fall_stb === 1'b1)) strobes_after++;
      if (rise_stb === 1'b1) last_rise_k = k;
      if (prev_locked && locked === 1'b0 && drop_k == 0) begin
        drop_k = k;
        n_checks++;
        if (period_valid !== 1'b0 || err_sticky !== 1'b1) begin
          n_fail++;
          $display("FAIL stop_flags valid=%b err=%b want valid=0 err=1", period_valid, err_sticky);
        end
      end
      prev_locked = (locked === 1'b1);
    end
    n_checks++;
    if (drop_k - last_rise_k != TMO) begin
      n_fail++;
      $display("FAIL stop_delay got=%0d want=%0d", drop_k - last_rise_k, TMO);
    end
    n_checks++;
    if (strobes_after != 0) begin
      n_fail++;
      $display("FAIL stop_strobes got=%0d want=0", strobes_after);
    end
    $display("test_stopped_clock done drop_delay=%0d", drop_k - last_rise_k);
  endtask

  task automatic test_clear_collision();
    bit collided = 0;
    int lone = 0;
    bit lv;
    bit cl;
    for (int i = 0; i < 11; i++) plan_period(2, 2, -1);
    plan_period(3, 3, -1);
    plan_period(2, 2, 2);
    plan_period(2, 2, -1);
    plan_period(2, 2, 1);
    plan_period(2, 2, -1);
    while (plan_lvl.size() > 0) begin
      lv = plan_lvl.pop_front();
      cl = plan_clr.pop_front();
      step(lv, cl);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL clr_model k=%0d got=%h want=%h", k, dut_vec, exp_vec);
      end
      if (rise_stb === 1'b1 && period === PW'(6)) begin
        collided = 1;
        n_checks++;
        if (err_sticky !== 1'b1 || locked !== 1'b0) begin
          n_fail++;
          $display("FAIL clr_collision err=%b locked=%b want err=1 locked=0", err_sticky, locked);
        end
      end else if (cl && collided) begin
        lone++;
        n_checks++;
        if (err_sticky !== 1'b0) begin
          n_fail++;
          $display("FAIL clr_lone got=%b want=0", err_sticky);
        end
      end
    end
    n_checks++;
    if (lone != 1) begin
      n_fail++;
      $display("FAIL clr_scenario collided=%0d lone=%0d want 1,1", collided, lone);
    end
    $display("test_clear_collision done collided=%0d", collided);
  endtask

  task automatic test_async_reset();
    int rises = 0;
    bit lv;
    bit cl;
    for (int i = 0; i < 11; i++) plan_period(2, 2, -1);
    while (plan_lvl.size() > 0) begin
      lv = plan_lvl.pop_front();
      cl = plan_clr.pop_front();
      step(lv, cl);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL arst_model k=%0d got=%h want=%h", k, dut_vec, exp_vec);
      end
    end
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre_lock got=%b want=1", locked);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== {VW{1'b0}}) begin
      n_fail++;
      $display("FAIL arst_clear got=%h want=0", dut_vec);
    end
    @(negedge clk_100mhz);
    @(negedge clk_100mhz);
    rst_n = 1'b1;
    model_reset();
    plan_period(2, 2, -1);
    plan_period(0, 3, -1);
    while (plan_lvl.size() > 0) begin
      lv = plan_lvl.pop_front();
      cl = plan_clr.pop_front();
      step(lv, cl);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL arst_after k=%0d got=%h want=%h", k, dut_vec, exp_vec);
      end
      if (rise_stb === 1'b1) begin
        rises++;
        n_checks++;
        if (period_valid !== 1'b0 || locked !== 1'b0) begin
          n_fail++;
          $display("FAIL arst_first_rise valid=%b locked=%b want 0,0", period_valid, locked);
        end
      end
    end
    n_checks++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL arst_rise_count got=%0d want=1", rises);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_stats();
    logic [15:0] want;
    bit lv;
    bit cl;
`ifdef CLK_MON_STATS_EN
    want = 16'd4;
`else
    want = 16'd0;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) plan_period(3, 2, -1);
    plan_period(3, 80, -1);
    while (plan_lvl.size() > 0) begin
      lv = plan_lvl.pop_front();
      cl = plan_clr.pop_front();
      step(lv, cl);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL stats_model k=%0d got=%h want=%h", k, dut_vec, exp_vec);
      end
    end
    n_checks++;
    if (bad_cnt !== want) begin
      n_fail++;
      $display("FAIL stats_bad_cnt got=%0d want=%0d", bad_cnt, want);
    end
    $display("test_stats done bad_cnt=%0d", bad_cnt);
  endtask

  task automatic test_random();
    int r;
    int hi;
    int lo;
    int ca;
    int locks = 0;
    bit lv;
    bit cl;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 15);
      if (r < 13) begin
        hi = 2;
        lo = 2;
      end else if (r == 15) begin
        hi = 2;
        lo = 70;
      end else begin
        hi = $urandom_range(1, 4);
        lo = $urandom_range(1, 4);
      end
      ca = ($urandom_range(0, 7) == 0) ? $urandom_range(0, hi + lo - 1) : -1;
      plan_period(hi, lo, ca);
    end
    while (plan_lvl.size() > 0) begin
      lv = plan_lvl.pop_front();
      cl = plan_clr.pop_front();
      step(lv, cl);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random_model k=%0d got=%h want=%h", k, dut_vec, exp_vec);
      end
      if (m_locked) locks++;
    end
    $display("test_random done cycles=%0d locked_cycles=%0d", k, locks);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_acquire();
    test_bad_period();
    test_stopped_clock();
    test_clear_collision();
    test_async_reset();
    test_stats();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
